decode_hazard_unit: RTL
=======================

# decode_hazard_unit

Decode-stage hazard and issue controller for the LC-3b pipeline. It sits directly downstream of the decode control ROM and consumes its `uses_sr1`, `uses_sr2`, `uses_dest`, `branch` and `read_memory` flags together with the register fields. It keeps a three-entry scoreboard of in-flight destinations (EX, MEM, WB) and performs the following:

- stalls decode on load-use hazards;
- holds fetch while a control transfer is unresolved;
- produces registered forwarding selects for the EX stage;
- keeps saturating stall counters for performance analysis.

## Interface
Parameters:
- CNT_W, 16, width of each saturating stall counter.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  pipeline clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  IF/ID register holds a valid instruction.
- id_uses_sr1, id_uses_sr2, id_uses_dest  in  1 each  control-word operand-use flags.
- id_branch  in  1  control-word branch flag (BR, JMP, JSR, TRAP).
- id_read_memory  in  1  control-word memory-read flag.
- id_sr1, id_sr2, id_dest  in  3 each  register numbers of the decode instruction.
- pipe_advance  in  1  pipeline moves this cycle; 0 means the memory stall freezes all stages.
- br_resolved  in  1  MEM stage has resolved the outstanding control transfer this cycle.
- stall_id  out  1  hold IF/ID contents (combinational).
- inject_bubble  out  1  EX receives a bubble this cycle (combinational).
- fetch_hold  out  1  fetch must not advance the PC (combinational).
- ex_fwd_sr1_sel, ex_fwd_sr2_sel  out  2 each  registered; 0 selects the regfile, 1 selects the EX/MEM result, 2 selects the MEM/WB result.
- load_stall_cnt, branch_stall_cnt  out  CNT_W each  saturating event counters.

## Operation
Scoreboard:
- S0 = EX, S1 = MEM, S2 = WB. Each entry holds {v, dest[2:0], ld}.
- The regfile is write-through, so S2 is never forwarded. It is retained only for the v/dest history.

Core decode signals:
- `hz` = S0.v & S0.ld & ((id_uses_sr1 & id_sr1==S0.dest) | (id_uses_sr2 & id_sr2==S0.dest)).
- `issue` = id_valid & state==RUN & ~hz & pipe_advance.

Outputs:
- stall_id = id_valid & (state==BR_WAIT | hz).
- inject_bubble = pipe_advance & ~issue.
- fetch_hold = state==BR_WAIT | (issue & id_branch).

Scoreboard update:
- When pipe_advance=1: S2←S1, S1←S0, and S0←{id_uses_dest, id_dest, id_read_memory} if `issue`, else S0←0.
- When pipe_advance=0: all entries hold.

Forwarding selects (per source n):
- Updated only when pipe_advance=1.
- If `issue`, the select is computed against the pre-shift entries:
  - 1 if S0.v & srcn==S0.dest;
  - else 2 if S1.v & srcn==S1.dest;
  - else 0.
- The S0 match takes priority (younger producer wins).
- If the source is unused, or on a bubble, the select is 0.

FSM (2 states):
- RUN: `issue` & id_branch → BR_WAIT; otherwise stay in RUN.
- BR_WAIT: br_resolved → RUN. This transition is independent of pipe_advance. No issue occurs while in BR_WAIT.
- br_resolved is ignored in RUN.

Counters:
- load_stall_cnt increments on each cycle with id_valid & state==RUN & hz & pipe_advance.
- branch_stall_cnt increments on each cycle with state==BR_WAIT.
- Both counters saturate at all-ones (no wrap).

## Timing
- Reset values: state=RUN, all scoreboard entries 0, ex_fwd_*_sel=0, both counters 0.
- With id_valid=0 and pipe_advance=1 after reset, the combinational outputs are stall_id=0, inject_bubble=1 and fetch_hold=0.
- Latency:
  - stall_id, inject_bubble and fetch_hold settle in the same cycle as their inputs.
  - Forwarding selects are valid in the cycle after issue, aligned with the instruction in EX.
- A load-use pair stalls exactly 1 cycle. On the retry the load sits in S1, so the consumer's select is 2.
- Branch penalty: fetch_hold is asserted from the issue cycle through the cycle in which br_resolved is asserted. It deasserts the cycle after resolution.
- Reset asserted mid-BR_WAIT or mid-stall: next state is RUN with a cleared scoreboard. This overrides all other inputs.
- pipe_advance=0 in RUN with a hazard present: stall_id=1 and there is no counter increment.

## Test plan
- Reset, then ADD R1←R2,R3 followed by ADD R4←R1,R1 back-to-back → no stall; the second instruction's ex_fwd_sr1_sel and ex_fwd_sr2_sel both equal 1 one cycle after its issue.
- LDR R2 followed by AND R5←R2,R6 → stall_id=1 and inject_bubble=1 for exactly 1 cycle; then issue with ex_fwd_sr1_sel=2; load_stall_cnt=1.
- BR issued, br_resolved asserted 3 cycles later → fetch_hold high for 4 cycles; state returns to RUN; branch_stall_cnt=3.
- Same load-use pair with pipe_advance=0 for 5 cycles during the hazard → scoreboard frozen; load_stall_cnt unchanged during the freeze and increments by 1 only after pipe_advance returns high.
- Reset pulsed while in BR_WAIT with S0–S2 valid → next cycle state=RUN, fetch_hold=0, ex_fwd selects 0, counters 0.
- Preload load_stall_cnt to 0xFFFF via repeated hazards (or force), then one more hazard → count remains 0xFFFF.

Source files
------------

// File: rtl/decode_hazard_unit.sv
// Decode-stage hazard/issue controller for the LC-3b pipeline: load-use stalls,
// branch fetch hold, registered EX forwarding selects and saturating stall counters.
module decode_hazard_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic             id_uses_sr1,
    input  logic             id_uses_sr2,
    input  logic             id_uses_dest,
    input  logic             id_branch,
    input  logic             id_read_memory,
    input  logic [2:0]       id_sr1,
    input  logic [2:0]       id_sr2,
    input  logic [2:0]       id_dest,
    input  logic             pipe_advance,
    input  logic             br_resolved,
    output logic             stall_id,
    output logic             inject_bubble,
    output logic             fetch_hold,
    output logic [1:0]       ex_fwd_sr1_sel,
    output logic [1:0]       ex_fwd_sr2_sel,
    output logic [CNT_W-1:0] load_stall_cnt,
    output logic [CNT_W-1:0] branch_stall_cnt
);

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_BR_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic       v;
        logic [2:0] dest;
        logic       ld;
    } sb_entry_t;

    state_t     r_state;
    state_t     w_state_nxt;
    sb_entry_t  r_sb0;
    sb_entry_t  r_sb1;
    sb_entry_t  r_sb2;
    logic [1:0] r_fwd_sr1_sel;
    logic [1:0] r_fwd_sr2_sel;
    logic [CNT_W-1:0] r_load_cnt;
    logic [CNT_W-1:0] r_branch_cnt;

    logic       w_br_wait;
    logic       w_hz;
    logic       w_issue;
    logic       w_load_inc;
    logic [1:0] w_sel1;
    logic [1:0] w_sel2;

    // Younger producer (EX) wins; WB is never forwarded because the regfile is write-through.
    function automatic logic [1:0] fwd_sel(input logic use_src, input logic [2:0] src,
                                           input sb_entry_t s0, input sb_entry_t s1);
        if (use_src && s0.v && src == s0.dest)
            return 2'd1;
        else if (use_src && s1.v && src == s1.dest)
            return 2'd2;
        else
            return 2'd0;
    endfunction

    assign w_br_wait  = (r_state == ST_BR_WAIT);
    assign w_hz       = r_sb0.v & r_sb0.ld &
                        ((id_uses_sr1 & (id_sr1 == r_sb0.dest)) |
                         (id_uses_sr2 & (id_sr2 == r_sb0.dest)));
    assign w_issue    = id_valid & ~w_br_wait & ~w_hz & pipe_advance;
    assign w_load_inc = id_valid & ~w_br_wait & w_hz & pipe_advance;

    assign stall_id      = id_valid & (w_br_wait | w_hz);
    assign inject_bubble = pipe_advance & ~w_issue;
    assign fetch_hold    = w_br_wait | (w_issue & id_branch);

    assign w_sel1 = w_issue ? fwd_sel(id_uses_sr1, id_sr1, r_sb0, r_sb1) : 2'd0;
    assign w_sel2 = w_issue ? fwd_sel(id_uses_sr2, id_sr2, r_sb0, r_sb1) : 2'd0;

    // NOTE: next-state defaults to the current state first so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:     if (w_issue && id_branch) w_state_nxt = ST_BR_WAIT;
            ST_BR_WAIT: if (br_resolved)          w_state_nxt = ST_RUN;
            default:                              w_state_nxt = ST_RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so the shift reads pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_RUN;
            r_sb0         <= '0;
            r_sb1         <= '0;
            r_sb2         <= '0;
            r_fwd_sr1_sel <= 2'd0;
            r_fwd_sr2_sel <= 2'd0;
            r_load_cnt    <= '0;
            r_branch_cnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (pipe_advance) begin
                r_sb2         <= r_sb1;
                r_sb1         <= r_sb0;
                r_sb0         <= w_issue ? sb_entry_t'{v: id_uses_dest, dest: id_dest, ld: id_read_memory}
                                         : sb_entry_t'('0);
                r_fwd_sr1_sel <= w_sel1;
                r_fwd_sr2_sel <= w_sel2;
            end
            if (w_load_inc && r_load_cnt != '1)
                r_load_cnt <= r_load_cnt + 1'b1;
            if (w_br_wait && r_branch_cnt != '1)
                r_branch_cnt <= r_branch_cnt + 1'b1;
        end
    end

    assign ex_fwd_sr1_sel   = r_fwd_sr1_sel;
    assign ex_fwd_sr2_sel   = r_fwd_sr2_sel;
    assign load_stall_cnt   = r_load_cnt;
    assign branch_stall_cnt = r_branch_cnt;

    // WB entry is history only; it must always mirror the previous MEM entry.
    sb2_tracks_sb1: assert property (@(posedge clk) disable iff (reset)
        ($past(pipe_advance) && !$past(reset)) |-> (r_sb2 == $past(r_sb1)));

endmodule
